// File: rtl/msx_audio_mixer.sv
// msx_audio_mixer: time-multiplexed N-channel audio mixer.
// Each accepted ce_sample snapshots all channel inputs, then a single
// signed x unsigned multiply-accumulate walks the channels one per cycle.
// The Q.3 sum is then floor-shifted and saturated to a signed IW-bit sample.
//
// Ports:
//   clk_sys    system clock
//   reset      synchronous, active-high reset
//   ce_sample  one-cycle strobe that starts a mix
//   ch_data    NCH packed IW-bit samples, channel k at [k*IW +: IW]
//   ch_signed  per channel: 1 = two's complement, 0 = offset binary
//   ch_gain    NCH packed GW-bit unsigned Q(GW-3).3 gains (8 = unity)
//   ch_mute    per channel: 1 = contributes zero
//   clip_clr   clears the sticky clip flag
//   audio_out  signed mixed sample, held between updates
//   out_valid  one-cycle pulse when audio_out updates
//   busy       high while a mix is in progress
//   clip       sticky saturation flag
//   overrun    sticky ignored-strobe flag, cleared only by reset
module msx_audio_mixer #(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = 16,
    parameter int unsigned GW  = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_sample,
    input  logic [NCH*IW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_signed,
    input  logic [NCH*GW-1:0] ch_gain,
    input  logic [NCH-1:0]    ch_mute,
    input  logic              clip_clr,
    output logic [IW-1:0]     audio_out,
    output logic              out_valid,
    output logic              busy,
    output logic              clip,
    output logic              overrun
);

    // Accumulator is wide enough for NCH full-scale products, so it never wraps.
    localparam int unsigned AW   = IW + GW + $clog2(NCH) + 1;
    localparam int unsigned PW   = IW + GW + 1;
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_SAT   = 2'd2;

    logic [1:0]              state, state_nxt;
    logic [IDXW-1:0]         idx, idx_nxt;
    logic signed [AW-1:0]    acc, acc_nxt;
    logic [NCH*IW-1:0]       snap_data, snap_data_nxt;
    logic [NCH-1:0]          snap_signed, snap_signed_nxt;
    logic [NCH*GW-1:0]       snap_gain, snap_gain_nxt;
    logic [NCH-1:0]          snap_mute, snap_mute_nxt;
    logic [IW-1:0]           audio_out_nxt;
    logic                    out_valid_nxt;
    logic                    busy_nxt;
    logic                    clip_nxt;
    logic                    overrun_nxt;

    // Datapath for the channel currently selected by idx.
    logic [IW-1:0]           cur_data;
    logic                    cur_signed;
    logic [GW-1:0]           cur_gain;
    logic                    cur_mute;
    logic signed [IW-1:0]    s_val;
    logic signed [GW:0]      g_val;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    add_term;
    logic signed [AW-1:0]    shifted;
    logic [AW-IW:0]          upper;
    logic                    sat_hit;

    // Select the current channel from the snapshot and form its weighted term.
    always_comb begin
        cur_data   = '0;
        cur_signed = 1'b0;
        cur_gain   = '0;
        cur_mute   = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (idx == IDXW'(k)) begin
                cur_data   = snap_data[k*IW +: IW];
                cur_signed = snap_signed[k];
                cur_gain   = snap_gain[k*GW +: GW];
                cur_mute   = snap_mute[k];
            end
        end
        // Offset binary becomes two's complement by flipping the MSB.
        s_val    = cur_signed ? cur_data : {~cur_data[IW-1], cur_data[IW-2:0]};
        g_val    = {1'b0, cur_gain};
        prod     = PW'(s_val) * PW'(g_val);
        add_term = cur_mute ? '0 : AW'(prod);
        // Drop the three fractional gain bits, rounding toward -inf.
        shifted  = acc >>> 3;
        upper    = shifted[AW-1:IW-1];
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        acc_nxt         = acc;
        snap_data_nxt   = snap_data;
        snap_signed_nxt = snap_signed;
        snap_gain_nxt   = snap_gain;
        snap_mute_nxt   = snap_mute;
        audio_out_nxt   = audio_out;
        out_valid_nxt   = 1'b0;
        busy_nxt        = busy;
        overrun_nxt     = overrun;
        sat_hit         = 1'b0;

        case (state)
            S_IDLE: begin
                if (ce_sample) begin
                    snap_data_nxt   = ch_data;
                    snap_signed_nxt = ch_signed;
                    snap_gain_nxt   = ch_gain;
                    snap_mute_nxt   = ch_mute;
                    acc_nxt         = '0;
                    idx_nxt         = '0;
                    busy_nxt        = 1'b1;
                    state_nxt       = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (ce_sample) overrun_nxt = 1'b1;
                acc_nxt = acc + add_term;
                if (idx == IDXW'(NCH - 1)) begin
                    state_nxt = S_SAT;
                end else begin
                    idx_nxt = idx + IDXW'(1);
                end
            end
            S_SAT: begin
                if (ce_sample) overrun_nxt = 1'b1;
                // In range only when all bits above the output sign agree.
                if ((&upper) || (~|upper)) begin
                    audio_out_nxt = shifted[IW-1:0];
                end else if (shifted[AW-1]) begin
                    audio_out_nxt = {1'b1, {(IW-1){1'b0}}};
                    sat_hit       = 1'b1;
                end else begin
                    audio_out_nxt = {1'b0, {(IW-1){1'b1}}};
                    sat_hit       = 1'b1;
                end
                out_valid_nxt = 1'b1;
                busy_nxt      = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        // A new saturation outranks a simultaneous clear.
        clip_nxt = clip;
        if (clip_clr) clip_nxt = 1'b0;
        if (sat_hit)  clip_nxt = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            acc         <= '0;
            snap_data   <= '0;
            snap_signed <= '0;
            snap_gain   <= '0;
            snap_mute   <= '0;
            audio_out   <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            acc         <= acc_nxt;
            snap_data   <= snap_data_nxt;
            snap_signed <= snap_signed_nxt;
            snap_gain   <= snap_gain_nxt;
            snap_mute   <= snap_mute_nxt;
            audio_out   <= audio_out_nxt;
            out_valid   <= out_valid_nxt;
            busy        <= busy_nxt;
            clip        <= clip_nxt;
            overrun     <= overrun_nxt;
        end
    end

endmodule
